boost_reg_control: RTL and testbench

- Parametrised successor to the two-slot, single-boost-level register-file control block.
- Supports NSLOT writeback slots and NBOOST nested boost levels. Holds the sequential bank pointer, per-level boosted-pending state and a stall-aware commit history internally, instead of taking them as inputs.
- Sits beside the register file in W. Generates write enables, destination bank pointers, boosted-valid flags, commit/squash qualification and exception-recovery classification for the shadow register bank.

---
 rtl/boost_reg_control_pkg.sv | 16 +
 rtl/boost_pend_level.sv | 17 +
 rtl/boost_reg_control.sv | 83 ++++++++
 tb/tb_boost_reg_control.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/boost_reg_control_pkg.sv
// boost_reg_control_pkg: TRSpec field offsets and width helpers shared by the boost control block
package boost_reg_control_pkg;
  // Each TRSpec slot field is packed as {valid, level}, with the level field at the bottom.
  localparam int BOOST_LSB = 0;
  // The valid bit sits directly above a level field of width lw.
  function automatic int validBit(input int lw);
    return BOOST_LSB + lw;
  endfunction
  // Bits needed to encode 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/boost_pend_level.sv
// boost_pend_level: pending-boosted-write flag for one boost level
module boost_pend_level (
  input  logic Phi1,
  input  logic nReset,
  input  logic clr,
  input  logic shift,
  input  logic accum,
  input  logic shiftIn,
  input  logic newWrite,
  output logic pend
);
  // The operations are tried in order: clear on squash or exception, shift down on commit,
  // otherwise accumulate new writes, and hold while stalled.
  always_ff @(posedge Phi1 or negedge nReset)
    if (!nReset) pend <= 1'b0;
    else pend <= clr ? 1'b0 : shift ? shiftIn : accum ? (pend | newWrite) : pend;
endmodule

// File: rtl/boost_reg_control.sv
// boost_reg_control: shadow-bank write, commit/squash and exception classification control
module boost_reg_control
  import boost_reg_control_pkg::*;
#(
  parameter  int NSLOT  = 2,
  parameter  int NBOOST = 1,
  parameter  int HIST   = 2,
  localparam int LW     = clog2(NBOOST + 1)
) (
  input  logic                    Phi1,
  input  logic                    nReset,
  input  logic                    Except_s1w,
  input  logic                    Stall_s1,
  input  logic                    Commit_s1e,
  input  logic                    Squash_s1e,
  input  logic [NSLOT-1:0]        SDSpec_w,
  input  logic [NSLOT*(LW+1)-1:0] TRSpec_w,
  output logic [NSLOT-1:0]        WBen_v1w,
  output logic [NSLOT-1:0]        DestPtr_v1e,
  output logic [NSLOT-1:0]        BnValid_v1e,
  output logic                    Commit_v1e,
  output logic                    Squash_v1e,
  output logic                    AfterBr_v1e,
  output logic                    SeqDefault_v1e,
  output logic                    SlotExcept_v1w,
  output logic                    BrExcept_v1w,
  output logic                    SeqPtr_s1,
  output logic [NBOOST-1:0]       BoostPend_s1
);
  localparam int VALID_BIT = validBit(LW);
  logic [NSLOT-1:0][LW-1:0] lvl;
  logic [NSLOT-1:0]         lvlOk;
  logic [NBOOST+1:1]        nw;
  logic [NBOOST+1:1]        pendX;
  logic [HIST-1:0]          prevCommit;
  assign pendX = {1'b0, BoostPend_s1};
  // Decode each slot's level. Levels above NBOOST are illegal and never mark a pending write.
  always_comb begin
    lvl = '0;
    lvlOk = '0;
    WBen_v1w = '0;
    BnValid_v1e = '0;
    DestPtr_v1e = '0;
    nw = '0;
    for (int i = 0; i < NSLOT; i++) begin
      lvl[i] = TRSpec_w[i*(LW+1)+BOOST_LSB +: LW];
      lvlOk[i] = TRSpec_w[i*(LW+1)+VALID_BIT] & (lvl[i] <= LW'(NBOOST));
      WBen_v1w[i] = SDSpec_w[i] & ~Except_s1w;
      BnValid_v1e[i] = lvlOk[i] & (lvl[i] != '0);
      DestPtr_v1e[i] = (lvl[i] == '0) ? SeqPtr_s1 : ~SeqPtr_s1;
      for (int k = 1; k <= NBOOST; k++) nw[k] = nw[k] | (BnValid_v1e[i] & (lvl[i] == LW'(k)));
    end
  end
  // Squash takes priority over a simultaneous commit. Stalls and exceptions block both.
  assign Squash_v1e     = Squash_s1e & ~Stall_s1 & ~Except_s1w;
  assign Commit_v1e     = Commit_s1e & ~Squash_s1e & ~Stall_s1 & ~Except_s1w;
  assign AfterBr_v1e    = ((Commit_s1e | Squash_s1e) & ~Stall_s1) | Except_s1w;
  assign SlotExcept_v1w = Except_s1w & |prevCommit[HIST-1:1];
  assign BrExcept_v1w   = Except_s1w & prevCommit[0] & ~SlotExcept_v1w;
  assign SeqDefault_v1e = ~Commit_v1e & ~BrExcept_v1w & ~SlotExcept_v1w;
  // On commit, level k+1 moves down to level k. Writes seen in the same cycle still use pre-commit numbering.
  for (genvar k = 1; k <= NBOOST; k++) begin : g_lvl
    boost_pend_level u_lvl (
      .Phi1     (Phi1),
      .nReset   (nReset),
      .clr      (Except_s1w | Squash_v1e),
      .shift    (Commit_v1e),
      .accum    (~Stall_s1),
      .shiftIn  (pendX[k+1] | nw[k+1]),
      .newWrite (nw[k]),
      .pend     (BoostPend_s1[k-1])
    );
  end
  // The shadow bank becomes architectural when a commit retires level-1 writes.
  always_ff @(posedge Phi1 or negedge nReset)
    if (!nReset) SeqPtr_s1 <= 1'b0;
    else if (Commit_v1e & (pendX[1] | nw[1])) SeqPtr_s1 <= ~SeqPtr_s1;
  // Commit history tracks how many slots ago the branch resolved. It is frozen while stalled.
  always_ff @(posedge Phi1 or negedge nReset)
    if (!nReset) prevCommit <= '0;
    else if (Except_s1w) prevCommit <= '0;
    else if (!Stall_s1) prevCommit <= {prevCommit[HIST-2:0], Commit_s1e};
endmodule

// File: tb/tb_boost_reg_control.sv
// tb_boost_reg_control: directed self-checking bench for boost_reg_control (NSLOT=2, NBOOST=2, HIST=3)
module tb_boost_reg_control;
  logic       Phi1, nReset, Except_s1w, Stall_s1, Commit_s1e, Squash_s1e;
  logic [1:0] SDSpec_w;
  logic [5:0] TRSpec_w;
  logic [1:0] WBen_v1w, DestPtr_v1e, BnValid_v1e, BoostPend_s1;
  logic       Commit_v1e, Squash_v1e, AfterBr_v1e, SeqDefault_v1e;
  logic       SlotExcept_v1w, BrExcept_v1w, SeqPtr_s1;
  int checks = 0;
  int failures = 0;

  boost_reg_control #(.NSLOT(2), .NBOOST(2), .HIST(3)) dut (
    .Phi1(Phi1), .nReset(nReset), .Except_s1w(Except_s1w), .Stall_s1(Stall_s1),
    .Commit_s1e(Commit_s1e), .Squash_s1e(Squash_s1e), .SDSpec_w(SDSpec_w), .TRSpec_w(TRSpec_w),
    .WBen_v1w(WBen_v1w), .DestPtr_v1e(DestPtr_v1e), .BnValid_v1e(BnValid_v1e),
    .Commit_v1e(Commit_v1e), .Squash_v1e(Squash_v1e), .AfterBr_v1e(AfterBr_v1e),
    .SeqDefault_v1e(SeqDefault_v1e), .SlotExcept_v1w(SlotExcept_v1w), .BrExcept_v1w(BrExcept_v1w),
    .SeqPtr_s1(SeqPtr_s1), .BoostPend_s1(BoostPend_s1)
  );

  initial Phi1 = 1'b0;
  always #5 Phi1 = ~Phi1;

  function automatic logic [2:0] tr(input logic v, input logic [1:0] l);
    return {v, l};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Phi1);
    #1;
  endtask

  initial begin
    nReset = 0; Except_s1w = 0; Stall_s1 = 0; Commit_s1e = 0; Squash_s1e = 0;
    SDSpec_w = 0; TRSpec_w = 0;
    #2;
    chk("rst_seqptr", SeqPtr_s1, 0);
    chk("rst_pend", BoostPend_s1, 0);
    chk("rst_commit", Commit_v1e, 0);
    chk("rst_seqdef", SeqDefault_v1e, 1);
    chk("rst_afterbr", AfterBr_v1e, 0);
    #10 nReset = 1;
    tick();
    // slot0 writes level 1, then commit
    TRSpec_w = {tr(0, 0), tr(1, 1)}; SDSpec_w = 2'b01;
    #1;
    chk("t1_bnvalid", BnValid_v1e, 2'b01);
    chk("t1_destptr", DestPtr_v1e, 2'b01);
    chk("t1_wben", WBen_v1w, 2'b01);
    tick();
    chk("t1_pend_a", BoostPend_s1, 2'b01);
    TRSpec_w = 0; SDSpec_w = 0; Commit_s1e = 1;
    #1;
    chk("t1_commit", Commit_v1e, 1);
    chk("t1_afterbr", AfterBr_v1e, 1);
    chk("t1_seqdef", SeqDefault_v1e, 0);
    tick();
    chk("t1_pend_b", BoostPend_s1, 2'b00);
    chk("t1_seqptr", SeqPtr_s1, 1);
    Commit_s1e = 0;
    #1;
    chk("t1_commit_off", Commit_v1e, 0);
    tick();
    // level-2 write, then two commits
    TRSpec_w = {tr(0, 0), tr(1, 2)};
    #1;
    chk("t2_destptr", DestPtr_v1e, 2'b10);
    tick();
    chk("t2_pend_a", BoostPend_s1, 2'b10);
    TRSpec_w = 0; Commit_s1e = 1;
    tick();
    chk("t2_pend_b", BoostPend_s1, 2'b01);
    chk("t2_seqptr_b", SeqPtr_s1, 1);
    tick();
    chk("t2_pend_c", BoostPend_s1, 2'b00);
    chk("t2_seqptr_c", SeqPtr_s1, 0);
    Commit_s1e = 0;
    // both levels pending, then commit and squash together
    TRSpec_w = {tr(1, 2), tr(1, 1)};
    tick();
    chk("t3_pend_a", BoostPend_s1, 2'b11);
    TRSpec_w = 0; Commit_s1e = 1; Squash_s1e = 1;
    #1;
    chk("t3_squash", Squash_v1e, 1);
    chk("t3_commit", Commit_v1e, 0);
    tick();
    chk("t3_pend_b", BoostPend_s1, 2'b00);
    chk("t3_seqptr", SeqPtr_s1, 0);
    Commit_s1e = 0; Squash_s1e = 0;
    // history 101 here; an exception clears it and blocks writes
    Except_s1w = 1; SDSpec_w = 2'b11;
    #1;
    chk("t4_wben_exc", WBen_v1w, 2'b00);
    chk("t4_slot_hist101", SlotExcept_v1w, 1);
    tick();
    Except_s1w = 0; SDSpec_w = 0;
    #1;
    Except_s1w = 1;
    #1;
    chk("t4_slot_hist0", SlotExcept_v1w, 0);
    chk("t4_br_hist0", BrExcept_v1w, 0);
    chk("t4_seqdef_hist0", SeqDefault_v1e, 1);
    Except_s1w = 0;
    Commit_s1e = 1;
    tick();
    Commit_s1e = 0;
    tick();
    tick();
    Except_s1w = 1;
    #1;
    chk("t4_slot_hist100", SlotExcept_v1w, 1);
    chk("t4_br_hist100", BrExcept_v1w, 0);
    tick();
    Except_s1w = 0;
    Commit_s1e = 1;
    tick();
    Commit_s1e = 0;
    tick();
    Except_s1w = 1;
    #1;
    chk("t4_slot_hist010", SlotExcept_v1w, 1);
    chk("t4_br_hist010", BrExcept_v1w, 0);
    tick();
    Except_s1w = 0;
    Commit_s1e = 1;
    tick();
    Commit_s1e = 0;
    Except_s1w = 1;
    #1;
    chk("t4_slot_hist001", SlotExcept_v1w, 0);
    chk("t4_br_hist001", BrExcept_v1w, 1);
    chk("t4_seqdef_br", SeqDefault_v1e, 0);
    tick();
    Except_s1w = 0;
    // stall three cycles between a commit and an exception
    Commit_s1e = 1;
    tick();
    Stall_s1 = 1;
    #1;
    chk("t5_commit_stall", Commit_v1e, 0);
    chk("t5_afterbr_stall", AfterBr_v1e, 0);
    tick();
    tick();
    tick();
    Stall_s1 = 0; Commit_s1e = 0; Except_s1w = 1;
    #1;
    chk("t5_br", BrExcept_v1w, 1);
    chk("t5_slot", SlotExcept_v1w, 0);
    tick();
    Except_s1w = 0;
    // illegal level 3 on slot0 alongside legal level 1 on slot1
    TRSpec_w = {tr(1, 1), tr(1, 3)};
    #1;
    chk("t6_bnvalid", BnValid_v1e, 2'b10);
    chk("t6_destptr", DestPtr_v1e, 2'b11);
    tick();
    chk("t6_pend_a", BoostPend_s1, 2'b01);
    TRSpec_w = 0; Commit_s1e = 1;
    tick();
    chk("t6_seqptr", SeqPtr_s1, 1);
    Commit_s1e = 0; TRSpec_w = {tr(0, 0), tr(1, 2)};
    tick();
    chk("t6_pend_b", BoostPend_s1, 2'b10);
    TRSpec_w = 0;
    #2 nReset = 0;
    #1;
    chk("t6_async_seqptr", SeqPtr_s1, 0);
    chk("t6_async_pend", BoostPend_s1, 2'b00);
    Except_s1w = 1;
    #0.5;
    chk("t6_async_slot", SlotExcept_v1w, 0);
    chk("t6_async_br", BrExcept_v1w, 0);
    Except_s1w = 0;
    #10 nReset = 1;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
